// File: rtl/nw_vc_requester.sv
// Input-port VC allocation requester: one small FSM per input VC that requests an
// output port, claims the lowest free downstream VC on grant and releases it on tail.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | no packet bound; waiting for a head flit at the buffer head
// ST_REQ    | route latched; requesting the output port while it has a free VC
// ST_ACTIVE | output VC bound; held until the tail flit leaves the switch
module nw_vc_requester #(
  parameter int np = 5,
  parameter int nv = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [nv-1:0]         head_valid,
  input  logic [nv*np-1:0]      head_route,
  input  logic [np*nv-1:0]      ovc_free,
  input  logic [nv*np-1:0]      grant,
  input  logic [nv-1:0]         tail_sent,
  output logic [nv*np-1:0]      request,
  output logic [nv-1:0]         alloc_valid,
  output logic [nv*np-1:0]      alloc_port,
  output logic [nv*nv-1:0]      alloc_ovc,
  output logic [nv*np*nv-1:0]   claim,
  output logic [nv*np*nv-1:0]   release_o,
  output logic                  grant_err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_ACTIVE = 2'd2
  } state_e;

  state_e                   state_q [nv];
  state_e                   state_d [nv];
  logic [nv-1:0][np-1:0]    route_q, route_d;
  logic [nv-1:0][nv-1:0]    ovc_q, ovc_d;
  logic                     grant_err_q, grant_err_d;

  logic [np-1:0]            port_free;
  logic [np-1:0][nv-1:0]    first_free;

  // Per output port: any free VC, and the lowest-index free VC as a one-hot.
  always_comb begin
    logic found;
    port_free  = '0;
    first_free = '0;
    found      = 1'b0;
    for (int op = 0; op < np; op++) begin
      port_free[op] = |ovc_free[op*nv +: nv];
      found = 1'b0;
      for (int i = 0; i < nv; i++) begin
        if (ovc_free[op*nv + i] && !found) begin
          first_free[op][i] = 1'b1;
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    logic [np-1:0] port_won;
    logic [np-1:0] req_v;
    logic [np-1:0] win_v;
    request     = '0;
    alloc_valid = '0;
    alloc_port  = '0;
    alloc_ovc   = '0;
    claim       = '0;
    release_o   = '0;
    grant_err_d = grant_err_q;
    port_won    = '0;
    req_v       = '0;
    win_v       = '0;
    for (int v = 0; v < nv; v++) begin
      state_d[v] = state_q[v];
      route_d[v] = route_q[v];
      ovc_d[v]   = ovc_q[v];

      req_v = '0;
      if (state_q[v] == ST_REQ) req_v = route_q[v] & port_free;
      win_v = req_v & grant[v*np +: np];
      request[v*np +: np] = req_v;

      // Stray grants and two winners on one port both flag the allocator as broken.
      if ((|(grant[v*np +: np] & ~req_v)) || (|(port_won & win_v))) grant_err_d = 1'b1;
      port_won = port_won | win_v;

      case (state_q[v])
        ST_IDLE: begin
          if (head_valid[v]) begin
            state_d[v] = ST_REQ;
            route_d[v] = head_route[v*np +: np];
          end
        end
        ST_REQ: begin
          if (|win_v) begin
            state_d[v] = ST_ACTIVE;
            ovc_d[v]   = '0;
            for (int op = 0; op < np; op++) begin
              if (win_v[op]) begin
                ovc_d[v] = ovc_d[v] | first_free[op];
                if (!rst) claim[(v*np + op)*nv +: nv] = first_free[op];
              end
            end
          end
        end
        ST_ACTIVE: begin
          alloc_valid[v]         = 1'b1;
          alloc_port[v*np +: np] = route_q[v];
          alloc_ovc[v*nv +: nv]  = ovc_q[v];
          if (tail_sent[v]) begin
            state_d[v] = ST_IDLE;
            route_d[v] = '0;
            ovc_d[v]   = '0;
            for (int op = 0; op < np; op++) begin
              if (route_q[v][op] && !rst) release_o[(v*np + op)*nv +: nv] = ovc_q[v];
            end
          end
        end
        default: begin
          state_d[v] = ST_IDLE;
          route_d[v] = '0;
          ovc_d[v]   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < nv; v++) state_q[v] <= ST_IDLE;
      route_q     <= '0;
      ovc_q       <= '0;
      grant_err_q <= 1'b0;
    end else begin
      for (int v = 0; v < nv; v++) state_q[v] <= state_d[v];
      route_q     <= route_d;
      ovc_q       <= ovc_d;
      grant_err_q <= grant_err_d;
    end
  end

  assign grant_err = grant_err_q;

endmodule

// File: tb/tb_nw_vc_requester.sv
// Bench for nw_vc_requester: directed handshake scenarios, then random traffic,
// all compared against a per-VC mode/route/ovc reference model.
module tb_nw_vc_requester;
  localparam int NP = 5;
  localparam int NV = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NV-1:0]        head_valid;
  logic [NV*NP-1:0]     head_route;
  logic [NP*NV-1:0]     ovc_free;
  logic [NV*NP-1:0]     grant;
  logic [NV-1:0]        tail_sent;
  logic [NV*NP-1:0]     request;
  logic [NV-1:0]        alloc_valid;
  logic [NV*NP-1:0]     alloc_port;
  logic [NV*NV-1:0]     alloc_ovc;
  logic [NV*NP*NV-1:0]  claim;
  logic [NV*NP*NV-1:0]  release_o;
  logic                 grant_err;

  nw_vc_requester #(.np(NP), .nv(NV)) dut (
    .clk(clk), .rst(rst), .head_valid(head_valid), .head_route(head_route),
    .ovc_free(ovc_free), .grant(grant), .tail_sent(tail_sent), .request(request),
    .alloc_valid(alloc_valid), .alloc_port(alloc_port), .alloc_ovc(alloc_ovc),
    .claim(claim), .release_o(release_o), .grant_err(grant_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: mode 0 idle, 1 requesting, 2 holding a VC.
  int m_mode [NV];
  int m_port [NV];
  int m_ovc  [NV];
  bit m_err;

  logic [NV*NP-1:0]    o_req;
  logic [NV-1:0]       o_av;
  logic [NV*NP-1:0]    o_ap;
  logic [NV*NV-1:0]    o_ao;
  logic [NV*NP*NV-1:0] o_claim;
  logic [NV*NP*NV-1:0] o_rel;
  logic                o_err;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int lowest(input logic [NV-1:0] f);
    for (int i = 0; i < NV; i++) if (f[i]) return i;
    return -1;
  endfunction

  function automatic int hot_idx(input logic [NP-1:0] x);
    for (int i = 0; i < NP; i++) if (x[i]) return i;
    return 0;
  endfunction

  function automatic logic [NV*NP-1:0] vp(input int v, input int op);
    logic [NV*NP-1:0] r;
    r = '0;
    r[v*NP + op] = 1'b1;
    return r;
  endfunction

  function automatic logic [NP*NV-1:0] fr(input int op, input logic [NV-1:0] f);
    logic [NP*NV-1:0] r;
    r = '0;
    r[op*NV +: NV] = f;
    return r;
  endfunction

  function automatic logic [NV*NP-1:0] model_req(input logic [NP*NV-1:0] of);
    logic [NV*NP-1:0] r;
    r = '0;
    for (int v = 0; v < NV; v++)
      if (m_mode[v] == 1 && of[m_port[v]*NV +: NV] != '0) r[v*NP + m_port[v]] = 1'b1;
    return r;
  endfunction

  task automatic step(input logic r, input logic [NV-1:0] hv, input logic [NV*NP-1:0] hr,
                      input logic [NP*NV-1:0] of, input logic [NV*NP-1:0] gr,
                      input logic [NV-1:0] ts, input bit do_chk);
    logic [NV*NP-1:0]    e_req;
    logic [NV*NP*NV-1:0] e_claim, e_rel;
    logic [NV-1:0]       e_av;
    logic [NV*NP-1:0]    e_ap;
    logic [NV*NV-1:0]    e_ao;
    int                  winners;
    bit                  bad;
    rst = r; head_valid = hv; head_route = hr; ovc_free = of; grant = gr; tail_sent = ts;
    #2;
    e_req = model_req(of);
    e_claim = '0; e_rel = '0; e_av = '0; e_ap = '0; e_ao = '0;
    for (int v = 0; v < NV; v++) begin
      if (m_mode[v] == 1 && !r && e_req[v*NP + m_port[v]] && gr[v*NP + m_port[v]])
        e_claim[(v*NP + m_port[v])*NV + lowest(of[m_port[v]*NV +: NV])] = 1'b1;
      if (m_mode[v] == 2) begin
        e_av[v] = 1'b1;
        e_ap[v*NP + m_port[v]] = 1'b1;
        e_ao[v*NV + m_ovc[v]] = 1'b1;
        if (ts[v] && !r) e_rel[(v*NP + m_port[v])*NV + m_ovc[v]] = 1'b1;
      end
    end
    o_req = request; o_av = alloc_valid; o_ap = alloc_port; o_ao = alloc_ovc;
    o_claim = claim; o_rel = release_o; o_err = grant_err;
    if (do_chk) begin
      chk("request", o_req, e_req);
      chk("claim", o_claim, e_claim);
      chk("release", o_rel, e_rel);
      chk("alloc_valid", o_av, e_av);
      chk("alloc_port", o_ap, e_ap);
      chk("alloc_ovc", o_ao, e_ao);
      chk("grant_err", o_err, m_err);
    end
    if (r) begin
      for (int v = 0; v < NV; v++) begin m_mode[v] = 0; m_port[v] = 0; m_ovc[v] = 0; end
      m_err = 1'b0;
    end else begin
      bad = |(gr & ~e_req);
      for (int op = 0; op < NP; op++) begin
        winners = 0;
        for (int v = 0; v < NV; v++) if (gr[v*NP + op] && e_req[v*NP + op]) winners++;
        if (winners > 1) bad = 1'b1;
      end
      if (bad) m_err = 1'b1;
      for (int v = 0; v < NV; v++) begin
        case (m_mode[v])
          0: if (hv[v]) begin m_mode[v] = 1; m_port[v] = hot_idx(hr[v*NP +: NP]); end
          1: if (e_req[v*NP + m_port[v]] && gr[v*NP + m_port[v]]) begin
               m_mode[v] = 2;
               m_ovc[v] = lowest(of[m_port[v]*NV +: NV]);
             end
          default: if (ts[v]) m_mode[v] = 0;
        endcase
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [NV-1:0]    hv, ts;
    logic [NV*NP-1:0] hr, gr, er;
    logic [NP*NV-1:0] of;
    logic [NP-1:0]    oh;
    int               cnt, pick;
    bit               r;
    for (int v = 0; v < NV; v++) begin m_mode[v] = 0; m_port[v] = 0; m_ovc[v] = 0; end
    m_err = 1'b0;
    #1;
    // Reset with arbitrary inputs, then quiet.
    step(1'b1, NV'($urandom), (NV*NP)'($urandom), (NP*NV)'($urandom), (NV*NP)'($urandom), NV'($urandom), 1'b0);
    step(1'b1, NV'($urandom), (NV*NP)'($urandom), (NP*NV)'($urandom), (NV*NP)'($urandom), NV'($urandom), 1'b1);
    step(1'b0, '0, '0, '0, '0, '0, 1'b1);
    step(1'b0, '0, '0, '0, '0, '0, 1'b1);
    chk("idle_quiet", {o_req, o_av, o_err}, '0);

    // Basic allocation on VC2 -> port 2, free VCs 0110.
    step(1'b0, 4'b0100, vp(2, 2), '0, '0, '0, 1'b1);
    step(1'b0, '0, '0, fr(2, 4'b0110), vp(2, 2), '0, 1'b1);
    chk("basic_req", o_req[2*NP + 2], 1'b1);
    chk("basic_claim", o_claim[(2*NP + 2)*NV + 1], 1'b1);
    step(1'b0, '0, '0, '0, '0, '0, 1'b1);
    chk("basic_av", o_av[2], 1'b1);
    chk("basic_port", o_ap[2*NP +: NP], 5'b00100);
    chk("basic_ovc", o_ao[2*NV +: NV], 4'b0010);
    chk("basic_claim_gone", o_claim, '0);

    // VC1 -> port 3 blocked for three cycles, then VC3 frees and wins.
    step(1'b0, 4'b0010, vp(1, 3), '0, '0, '0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, '0, '0, '0, '0, '0, 1'b1);
      chk("blk_req", o_req[NP + 3], 1'b0);
    end
    step(1'b0, '0, '0, fr(3, 4'b1000), vp(1, 3), '0, 1'b1);
    chk("blk_claim", o_claim[(NP + 3)*NV + 3], 1'b1);
    step(1'b0, '0, '0, '0, '0, '0, 1'b1);
    chk("blk_ovc", o_ao[NV +: NV], 4'b1000);

    // VC0 on (port 1, ovc 0): release, then immediate re-request.
    step(1'b0, 4'b0001, vp(0, 1), '0, '0, '0, 1'b1);
    step(1'b0, '0, '0, fr(1, 4'b0011), vp(0, 1), '0, 1'b1);
    step(1'b0, '0, '0, '0, '0, '0, 1'b1);
    step(1'b0, '0, '0, '0, '0, 4'b0001, 1'b1);
    chk("rel_pulse", o_rel[(0*NP + 1)*NV + 0], 1'b1);
    step(1'b0, 4'b0001, vp(0, 1), '0, '0, '0, 1'b1);
    chk("rel_av", o_av[0], 1'b0);
    chk("rel_once", o_rel, '0);
    step(1'b0, '0, '0, fr(1, 4'b0100), '0, '0, 1'b1);
    chk("rel_rereq", o_req[1], 1'b1);
    step(1'b0, '0, '0, fr(1, 4'b1111), vp(0, 1), 4'b0110, 1'b1);
    step(1'b0, '0, '0, '0, '0, 4'b0001, 1'b1);

    // Concurrent grants on distinct ports.
    step(1'b0, 4'b1001, vp(0, 0) | vp(3, 4), '0, '0, '0, 1'b1);
    step(1'b0, '0, '0, '1, vp(0, 0) | vp(3, 4), '0, 1'b1);
    chk("cc_claim0", o_claim[0], 1'b1);
    chk("cc_claim3", o_claim[(3*NP + 4)*NV], 1'b1);
    step(1'b0, '0, '0, '0, '0, '0, 1'b1);
    chk("cc_av", o_av, 4'b1001);

    // Stray grant to idle VC1, then reset while bound.
    step(1'b0, '0, '0, '1, vp(1, 3), '0, 1'b1);
    step(1'b0, '0, '0, '0, '0, '0, 1'b1);
    chk("err_set", o_err, 1'b1);
    chk("err_nostate", o_av[1], 1'b0);
    step(1'b0, '0, '0, '0, '0, '0, 1'b1);
    chk("err_sticky", o_err, 1'b1);
    step(1'b1, '0, '0, '0, '0, '0, 1'b1);
    chk("rst_norel", o_rel, '0);
    step(1'b0, '0, '0, '0, '0, '0, 1'b1);
    chk("rst_av", o_av, '0);
    chk("rst_err", o_err, 1'b0);

    // Random traffic with a well-behaved allocator plus rare stray grants and resets.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      r  = ($urandom_range(0, 99) == 0);
      hv = NV'($urandom);
      hr = '0;
      for (int v = 0; v < NV; v++) begin
        oh = '0;
        oh[$urandom_range(0, NP-1)] = 1'b1;
        hr[v*NP +: NP] = oh;
      end
      of = '0;
      for (int op = 0; op < NP; op++)
        if ($urandom_range(0, 2) != 0) of[op*NV +: NV] = NV'($urandom);
      ts = '0;
      for (int v = 0; v < NV; v++) ts[v] = ($urandom_range(0, 3) == 0);
      er = model_req(of);
      gr = '0;
      for (int op = 0; op < NP; op++) begin
        cnt = 0; pick = -1;
        for (int v = 0; v < NV; v++)
          if (er[v*NP + op]) begin
            cnt++;
            if ($urandom_range(0, cnt-1) == 0) pick = v;
          end
        if (pick >= 0 && $urandom_range(0, 9) < 7) gr[pick*NP + op] = 1'b1;
      end
      if ($urandom_range(0, 149) == 0) gr[$urandom_range(0, NV*NP-1)] = 1'b1;
      step(r, hv, hr, of, gr, ts, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
